// File: rtl/funcq_arbiter.sv
// funcq_arbiter: round-robin front end that shares one pipelined funcQ unit
// among NREQ requesters. Issued operations are tagged with the requester
// index in an in-order FIFO. Returning results are steered back to the
// requester at the head of that FIFO.
module funcq_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NREQ       = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_vld,
    output logic [NREQ-1:0]                req_rdy,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_a,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_b,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_c,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_d,
    output logic [NREQ-1:0]                rsp_vld,
    output logic [DATA_WIDTH-1:0]          rsp_q,
    output logic                           fq_data_vld,
    output logic [DATA_WIDTH-1:0]          fq_a,
    output logic [DATA_WIDTH-1:0]          fq_b,
    output logic [DATA_WIDTH-1:0]          fq_c,
    output logic [DATA_WIDTH-1:0]          fq_d,
    input  logic                           fq_q_vld,
    input  logic [DATA_WIDTH-1:0]          fq_q,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst,
    output logic                           err_unexp
);

    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    // Per-requester operand views of the packed input buses.
    logic [DATA_WIDTH-1:0] a_arr [NREQ];
    logic [DATA_WIDTH-1:0] b_arr [NREQ];
    logic [DATA_WIDTH-1:0] c_arr [NREQ];
    logic [DATA_WIDTH-1:0] d_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
        assign c_arr[g] = req_c[g*DATA_WIDTH +: DATA_WIDTH];
        assign d_arr[g] = req_d[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // State registers.
    logic                  armed_q,       armed_d;
    logic [TW-1:0]         rr_ptr_q,      rr_ptr_d;
    logic [OW-1:0]         outst_q,       outst_d;
    logic [PW-1:0]         wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,      rd_ptr_d;
    logic [TW-1:0]         tag_mem_q [MAX_OUTST];
    logic [TW-1:0]         tag_mem_d [MAX_OUTST];
    logic                  fq_data_vld_q, fq_data_vld_d;
    logic [DATA_WIDTH-1:0] fq_a_q,        fq_a_d;
    logic [DATA_WIDTH-1:0] fq_b_q,        fq_b_d;
    logic [DATA_WIDTH-1:0] fq_c_q,        fq_c_d;
    logic [DATA_WIDTH-1:0] fq_d_q,        fq_d_d;
    logic [NREQ-1:0]       rsp_vld_q,     rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q,     rsp_dat_d;
    logic                  err_unexp_q,   err_unexp_d;

    logic                  grant_open;
    logic                  gnt_vld;
    logic [TW-1:0]         gnt_idx;
    logic                  push;
    logic                  pop;

    // Advance a FIFO pointer with wrap at MAX_OUTST.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // A grant is possible only out of reset, after the first post-reset edge,
    // and only while the in-flight count is below the limit. A pop in the
    // same cycle does not reopen the grant; it reopens the cycle after.
    assign grant_open = rst && armed_q && (outst_q < OW'(MAX_OUTST));

    // Round-robin search starting at the priority pointer; pure function of
    // req_vld, the pointer and outst, so there is no combinational loop.
    always_comb begin
        int sum;
        logic [TW-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        req_rdy = '0;
        sum     = 0;
        cand    = '0;
        if (grant_open) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = int'(rr_ptr_q) + k;
                if (sum >= NREQ) sum = sum - NREQ;
                cand = TW'(sum);
                if (!gnt_vld && req_vld[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_vld) req_rdy[gnt_idx] = 1'b1;
    end

    // Next-state: tag FIFO push/pop, in-flight count, issue and return stages.
    always_comb begin
        push          = gnt_vld;
        pop           = fq_q_vld && (outst_q != '0);
        armed_d       = 1'b1;
        rr_ptr_d      = rr_ptr_q;
        outst_d       = outst_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_mem_d     = tag_mem_q;
        fq_data_vld_d = push;
        fq_a_d        = fq_a_q;
        fq_b_d        = fq_b_q;
        fq_c_d        = fq_c_q;
        fq_d_d        = fq_d_q;
        rsp_vld_d     = '0;
        rsp_dat_d     = rsp_dat_q;
        err_unexp_d   = fq_q_vld && (outst_q == '0);

        if (push) begin
            rr_ptr_d            = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
            tag_mem_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            fq_a_d              = a_arr[gnt_idx];
            fq_b_d              = b_arr[gnt_idx];
            fq_c_d              = c_arr[gnt_idx];
            fq_d_d              = d_arr[gnt_idx];
        end

        if (pop) begin
            rd_ptr_d                       = ptr_inc(rd_ptr_q);
            rsp_vld_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rsp_dat_d                      = fq_q;
        end

        if (push && !pop) outst_d = outst_q + OW'(1);
        else if (pop && !push) outst_d = outst_q - OW'(1);
    end

    // State update; asynchronous active-low reset empties the FIFO, drops
    // in-flight tags and returns priority to requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q       <= 1'b0;
            rr_ptr_q      <= '0;
            outst_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < MAX_OUTST; i++) tag_mem_q[i] <= '0;
            fq_data_vld_q <= 1'b0;
            fq_a_q        <= '0;
            fq_b_q        <= '0;
            fq_c_q        <= '0;
            fq_d_q        <= '0;
            rsp_vld_q     <= '0;
            rsp_dat_q     <= '0;
            err_unexp_q   <= 1'b0;
        end else begin
            armed_q       <= armed_d;
            rr_ptr_q      <= rr_ptr_d;
            outst_q       <= outst_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_mem_q     <= tag_mem_d;
            fq_data_vld_q <= fq_data_vld_d;
            fq_a_q        <= fq_a_d;
            fq_b_q        <= fq_b_d;
            fq_c_q        <= fq_c_d;
            fq_d_q        <= fq_d_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_dat_q     <= rsp_dat_d;
            err_unexp_q   <= err_unexp_d;
        end
    end

    assign outst       = outst_q;
    assign fq_data_vld = fq_data_vld_q;
    assign fq_a        = fq_a_q;
    assign fq_b        = fq_b_q;
    assign fq_c        = fq_c_q;
    assign fq_d        = fq_d_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_q       = rsp_dat_q;
    assign err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_funcq_arbiter.sv
// Directed bench for funcq_arbiter. The bench plays the role of funcQ and
// returns hand-computed results q = a*b + c*d for each requester's operands.
module tb_funcq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_vld;
    logic [3:0]  req_rdy;
    logic [63:0] req_a, req_b, req_c, req_d;
    logic [3:0]  rsp_vld;
    logic [15:0] rsp_q;
    logic        fq_data_vld;
    logic [15:0] fq_a, fq_b, fq_c, fq_d;
    logic        fq_q_vld;
    logic [15:0] fq_q;
    logic [2:0]  outst;
    logic        err_unexp;

    int total = 0;
    int bad   = 0;

    logic [15:0] op_a [4];
    logic [15:0] op_b [4];
    logic [15:0] op_c [4];
    logic [15:0] op_d [4];
    logic [15:0] gold [4];
    int          exp_gnt [5];

    funcq_arbiter #(.DATA_WIDTH(16), .NREQ(4), .MAX_OUTST(4)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .rsp_vld(rsp_vld), .rsp_q(rsp_q),
        .fq_data_vld(fq_data_vld),
        .fq_a(fq_a), .fq_b(fq_b), .fq_c(fq_c), .fq_d(fq_d),
        .fq_q_vld(fq_q_vld), .fq_q(fq_q),
        .outst(outst), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Operand table and hand-computed a*b + c*d results.
        op_a[0] = 16'd12;   op_b[0] = 16'd5;    op_c[0] = -16'sd2;  op_d[0] = 16'd3;  gold[0] = 16'd54;
        op_a[1] = 16'd7;    op_b[1] = -16'sd3;  op_c[1] = 16'd4;    op_d[1] = 16'd4;  gold[1] = -16'sd5;
        op_a[2] = 16'd100;  op_b[2] = 16'd3;    op_c[2] = -16'sd10; op_d[2] = 16'd2;  gold[2] = 16'd280;
        op_a[3] = -16'sd8;  op_b[3] = -16'sd8;  op_c[3] = 16'd1;    op_d[3] = 16'd1;  gold[3] = 16'd65;
        exp_gnt[0] = 0; exp_gnt[1] = 1; exp_gnt[2] = 2; exp_gnt[3] = 3; exp_gnt[4] = 0;
        req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
        req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
        req_c = {op_c[3], op_c[2], op_c[1], op_c[0]};
        req_d = {op_d[3], op_d[2], op_d[1], op_d[0]};

        // Reset state, with requests asserted to prove req_rdy is forced low.
        rst      = 1'b0;
        req_vld  = 4'hF;
        fq_q_vld = 1'b0;
        fq_q     = '0;
        tick(); tick(); tick();
        check("rst_req_rdy", 32'(req_rdy), 32'h0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'h0);
        check("rst_rsp_q", 32'(rsp_q), 32'h0);
        check("rst_fq_vld", 32'(fq_data_vld), 32'h0);
        check("rst_fq_a", 32'(fq_a), 32'h0);
        check("rst_outst", 32'(outst), 32'h0);
        check("rst_err", 32'(err_unexp), 32'h0);

        // Single request from requester 0; no grant before the first edge.
        rst     = 1'b1;
        req_vld = 4'b0001;
        #1;
        check("arm_no_grant", 32'(req_rdy), 32'h0);
        tick();
        check("single_rdy", 32'(req_rdy), 32'b0001);
        tick();
        req_vld = 4'b0000;
        check("single_fq_vld", 32'(fq_data_vld), 32'h1);
        check("single_fq_a", 32'(fq_a), 32'h000C);
        check("single_fq_b", 32'(fq_b), 32'h0005);
        check("single_fq_c", 32'(fq_c), 32'hFFFE);
        check("single_fq_d", 32'(fq_d), 32'h0003);
        check("single_outst", 32'(outst), 32'h1);
        tick();
        check("single_fq_vld_drop", 32'(fq_data_vld), 32'h0);
        check("single_fq_a_hold", 32'(fq_a), 32'h000C);
        fq_q_vld = 1'b1;
        fq_q     = gold[0];
        tick();
        fq_q_vld = 1'b0;
        check("single_rsp_vld", 32'(rsp_vld), 32'b0001);
        check("single_rsp_q", 32'(rsp_q), 32'd54);
        check("single_outst_back", 32'(outst), 32'h0);
        tick();
        check("single_rsp_vld_drop", 32'(rsp_vld), 32'h0);
        check("single_rsp_q_hold", 32'(rsp_q), 32'd54);

        // Fresh reset, then all four requesters held valid; funcQ answers
        // one cycle after each issue.
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        for (int n = 0; n < 7; n++) begin
            req_vld  = (n < 5) ? 4'hF : 4'h0;
            fq_q_vld = (n >= 1 && n <= 5);
            fq_q     = (n >= 1 && n <= 5) ? gold[exp_gnt[n-1]] : 16'h0;
            if (n >= 1 && n <= 5) begin
                check("rr_fq_vld", 32'(fq_data_vld), 32'h1);
                check("rr_fq_a", 32'(fq_a), 32'(op_a[exp_gnt[n-1]]));
                check("rr_fq_d", 32'(fq_d), 32'(op_d[exp_gnt[n-1]]));
            end else begin
                check("rr_fq_idle", 32'(fq_data_vld), 32'h0);
            end
            if (n >= 2) begin
                check("rr_rsp_vld", 32'(rsp_vld), 32'(4'b0001 << exp_gnt[n-2]));
                check("rr_rsp_q", 32'(rsp_q), 32'(gold[exp_gnt[n-2]]));
            end
            check("rr_outst", 32'(outst), (n >= 1 && n <= 5) ? 32'h1 : 32'h0);
            #1;
            check("rr_req_rdy", 32'(req_rdy), (n < 5) ? 32'(4'b0001 << exp_gnt[n]) : 32'h0);
            tick();
        end

        // Stalled funcQ: four issues (1,2,3,0) fill the tag FIFO.
        req_vld  = 4'hF;
        fq_q_vld = 1'b0;
        #1; check("fill_rdy0", 32'(req_rdy), 32'b0010); tick();
        #1; check("fill_rdy1", 32'(req_rdy), 32'b0100); tick();
        #1; check("fill_rdy2", 32'(req_rdy), 32'b1000); tick();
        #1; check("fill_rdy3", 32'(req_rdy), 32'b0001); tick();
        check("full_outst", 32'(outst), 32'h4);
        fq_q_vld = 1'b1;
        fq_q     = gold[1];
        #1;
        check("full_pop_no_grant", 32'(req_rdy), 32'h0);
        tick();
        fq_q_vld = 1'b0;
        check("full_rsp_vld", 32'(rsp_vld), 32'b0010);
        check("full_rsp_q", 32'(rsp_q), 32'(gold[1]));
        check("full_outst_3", 32'(outst), 32'h3);
        check("full_no_issue", 32'(fq_data_vld), 32'h0);
        #1;
        check("reopen_rdy", 32'(req_rdy), 32'b0010);
        tick();
        check("reopen_issue", 32'(fq_data_vld), 32'h1);
        check("reopen_fq_a", 32'(fq_a), 32'(op_a[1]));
        check("reopen_outst", 32'(outst), 32'h4);

        // Drain two results to reach outst=2 (tags 2 then 3).
        req_vld  = 4'h0;
        fq_q_vld = 1'b1;
        fq_q     = gold[2];
        tick();
        check("drain_rsp2", 32'(rsp_vld), 32'b0100);
        check("drain_outst3", 32'(outst), 32'h3);
        fq_q = gold[3];
        tick();
        check("drain_rsp3", 32'(rsp_vld), 32'b1000);
        check("drain_q3", 32'(rsp_q), 32'(gold[3]));
        check("drain_outst2", 32'(outst), 32'h2);

        // Simultaneous grant (requester 2) and pop (tag 0) at outst=2.
        req_vld  = 4'b0100;
        fq_q_vld = 1'b1;
        fq_q     = gold[0];
        #1;
        check("both_rdy", 32'(req_rdy), 32'b0100);
        tick();
        check("both_outst", 32'(outst), 32'h2);
        check("both_rsp_vld", 32'(rsp_vld), 32'b0001);
        check("both_rsp_q", 32'(rsp_q), 32'(gold[0]));
        check("both_fq_vld", 32'(fq_data_vld), 32'h1);
        check("both_fq_a", 32'(fq_a), 32'(op_a[2]));
        req_vld = 4'h0;
        fq_q    = gold[1];
        tick();
        check("tail_rsp1", 32'(rsp_vld), 32'b0010);
        check("tail_q1", 32'(rsp_q), 32'hFFFB);
        check("tail_outst1", 32'(outst), 32'h1);
        fq_q = gold[2];
        tick();
        fq_q_vld = 1'b0;
        check("tail_rsp2", 32'(rsp_vld), 32'b0100);
        check("tail_outst0", 32'(outst), 32'h0);
        tick();
        check("tail_idle", 32'(rsp_vld), 32'h0);

        // Unexpected result with nothing in flight.
        fq_q_vld = 1'b1;
        fq_q     = 16'h7777;
        tick();
        fq_q_vld = 1'b0;
        check("unexp_err", 32'(err_unexp), 32'h1);
        check("unexp_rsp_vld", 32'(rsp_vld), 32'h0);
        check("unexp_outst", 32'(outst), 32'h0);
        check("unexp_rsp_q_hold", 32'(rsp_q), 32'd280);
        tick();
        check("unexp_err_drop", 32'(err_unexp), 32'h0);

        // Three operations in flight (grants 3,0,1), then reset mid-operation.
        req_vld = 4'hF;
        tick(); tick(); tick();
        check("pre_rst_outst", 32'(outst), 32'h3);
        check("pre_rst_fq_a", 32'(fq_a), 32'(op_a[1]));
        rst = 1'b0;
        #1;
        check("mid_rst_outst", 32'(outst), 32'h0);
        check("mid_rst_fq_vld", 32'(fq_data_vld), 32'h0);
        check("mid_rst_fq_a", 32'(fq_a), 32'h0);
        check("mid_rst_rsp_q", 32'(rsp_q), 32'h0);
        check("mid_rst_rdy", 32'(req_rdy), 32'h0);
        tick(); tick();
        rst      = 1'b1;
        fq_q_vld = 1'b1;
        fq_q     = gold[3];
        #1;
        check("post_rst_arm", 32'(req_rdy), 32'h0);
        tick();
        fq_q_vld = 1'b0;
        check("late_err", 32'(err_unexp), 32'h1);
        check("late_rsp_vld", 32'(rsp_vld), 32'h0);
        check("late_outst", 32'(outst), 32'h0);
        #1;
        check("post_rst_rdy0", 32'(req_rdy), 32'b0001);
        tick();
        req_vld = 4'h0;
        check("post_rst_issue", 32'(fq_data_vld), 32'h1);
        check("post_rst_fq_a", 32'(fq_a), 32'h000C);
        check("post_rst_outst", 32'(outst), 32'h1);
        check("post_rst_err_drop", 32'(err_unexp), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
